div: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div.sv | 137 +++++++++++++
 tb/tb_div.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the iterative radix-2 divider: FSM states and
// the ready/start/reset level constants used by the EX stage.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        RstEnable         = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0;

endpackage

// File: rtl/div.sv
// Iterative radix-2 restoring divider producing {remainder, quotient} for HI/LO.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int               CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  div_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem, quo, divisor;
  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     sub;
  logic                sub_neg;
  logic [DATA_W-1:0]   step_rem, step_quo, fin_rem, fin_quo;
  logic [DATA_W-1:0]   mag1, mag2;
  logic                go;

  assign go = (start_i == DivStart) && !annul_i;

  // quo holds the not-yet-consumed dividend bits; its MSB feeds the partial
  // remainder while quotient bits shift in at the bottom.
  assign partial = {rem, quo[DATA_W-1]};
  assign sub     = {1'b0, partial[DATA_W-1:0]} - {1'b0, divisor};
  // A set partial MSB means partial >= 2^W > divisor, so the subtract always fits.
  assign sub_neg = !partial[DATA_W] && sub[DATA_W];

  always_comb begin
    step_quo = {quo[DATA_W-2:0], !sub_neg};
    step_rem = sub_neg ? partial[DATA_W-1:0] : sub[DATA_W-1:0];
  end

`ifdef DIV_SIGNED_EN
  logic neg1, neg2, neg_quo, neg_rem;

  assign neg1    = signed_div_i && opdata1_i[DATA_W-1];
  assign neg2    = signed_div_i && opdata2_i[DATA_W-1];
  assign mag1    = neg1 ? -opdata1_i : opdata1_i;
  assign mag2    = neg2 ? -opdata2_i : opdata2_i;
  assign fin_quo = neg_quo ? -step_quo : step_quo;
  assign fin_rem = neg_rem ? -step_rem : step_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == DivFree && go) begin
      neg_quo <= neg1 ^ neg2;
      neg_rem <= neg1;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = signed_div_i;
  assign mag1        = opdata1_i;
  assign mag2        = opdata2_i;
  assign fin_quo     = step_quo;
  assign fin_rem     = step_rem;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (go) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              cnt     <= '0;
              rem     <= '0;
              quo     <= mag1;
              divisor <= mag2;
            end
          end
        end
        DivByZero: begin
          rem   <= '0;
          quo   <= '0;
          state <= annul_i ? DivFree : DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              rem   <= fin_rem;
              quo   <= fin_quo;
              state <= DivEnd;
            end else begin
              rem <= step_rem;
              quo <= step_quo;
            end
          end
        end
        DivEnd: begin
          // EX holds start until it has consumed the result; a flush reads as release.
          if (go) begin
            ready_o  <= DivResultReady;
            result_o <= {rem, quo};
          end else begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: transaction-level model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_div;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_div = 1'b0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic [2*W-1:0] result;
  logic           ready;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;
  chk_t pend[$];

  div #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: truncating quotient, remainder follows the dividend.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return '0;
    if (SIGNED_EN && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Transaction model: ready appears W+1 edges after accept (2 for divide by zero).
  logic [2*W-1:0] m_res = '0;
  logic [2*W-1:0] exp_res = '0;
  logic           exp_ready = 1'b0;
  int             m_left = 0;
  bit             m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left    <= 0;
      m_done    <= 1'b0;
      exp_ready <= 1'b0;
      exp_res   <= '0;
    end else if (m_done) begin
      if (start && !annul) begin
        exp_ready <= 1'b1;
        exp_res   <= m_res;
      end else begin
        m_done    <= 1'b0;
        exp_ready <= 1'b0;
        exp_res   <= '0;
      end
    end else if (m_left > 0) begin
      if (annul) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end
    end else if (start && !annul) begin
      m_res  <= ref_div(op1, op2, signed_div);
      m_left <= (op2 == '0) ? 1 : W;
    end
  end

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready_o", 64'(ready), 64'(exp_ready));
    check("result_o", result, exp_res);
    while (pend.size() > 0) begin
      chk_t c;
      c = pend.pop_front();
      check(c.name, c.act, c.exp);
    end
  end

  task automatic expect_eq(input string n, input logic [63:0] a, input logic [63:0] e);
    pend.push_back('{n, a, e});
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input int hold, output int lat, output logic [2*W-1:0] res);
    int c_set;
    bit got;
    op1 = a; op2 = b; signed_div = sgn; start = 1'b1;
    c_set = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        lat = cyc - (c_set + 1);
      end
    end
    if (!got) expect_eq("ready_timeout", 64'd0, 64'd1);
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      expect_eq("hold_result", result, res);
      expect_eq("hold_ready", 64'(ready), 64'd1);
    end
    start = 1'b0;
    op1 = '0; op2 = '0;
    @(negedge clk);
    expect_eq("release_ready", 64'(ready), 64'd0);
  endtask

  initial begin
    logic [2*W-1:0] r;
    int lat;
    bit seen;

    repeat (2) @(negedge clk);
    expect_eq("reset_ready", 64'(ready), 64'd0);
    expect_eq("reset_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, 0, lat, r);
    expect_eq("lat_100_7", 64'(lat), 64'd33);
    expect_eq("res_100_7", r, {32'd2, 32'd14});

    run_op(32'd5, 32'd0, 1'b0, 0, lat, r);
    expect_eq("lat_div0", 64'(lat), 64'd2);
    expect_eq("res_div0", r, 64'd0);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5, lat, r);
    expect_eq("res_max_1", r, {32'd0, 32'hFFFF_FFFF});

    run_op(32'd7, 32'd100, 1'b0, 0, lat, r);
    expect_eq("res_7_100", r, {32'd7, 32'd0});

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat, r);
    expect_eq("res_max_max", r, {32'd0, 32'd1});

    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, lat, r);
    expect_eq("res_big_divisor", r, {32'h7FFF_FFFE, 32'd1});

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, r);
    expect_eq("res_min_m1_unsigned", r, {32'h8000_0000, 32'd0});

    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 2, lat, r);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, lat, r);
    expect_eq("res_m7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, lat, r);
    expect_eq("res_7_m2", r, {32'd1, 32'hFFFF_FFFD});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, lat, r);
    expect_eq("res_min_m1_signed", r, {32'd0, 32'h8000_0000});
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, lat, r);
    expect_eq("res_sign_ignored", r, {32'd1, 32'h7FFF_FFFC});
`endif

    // Annul mid-operation: no ready may follow, then a fresh op completes.
    op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready;
    end
    expect_eq("annul_no_ready", 64'(seen), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, 0, lat, r);
    expect_eq("lat_after_annul", 64'(lat), 64'd33);
    expect_eq("res_9_3", r, {32'd0, 32'd3});

    // Reset mid-operation.
    op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0; start = 1'b0;
    #1;
    expect_eq("rst_mid_ready", 64'(ready), 64'd0);
    expect_eq("rst_mid_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(32'd100, 32'd7, 1'b0, 0, lat, r);
    expect_eq("lat_after_rst", 64'(lat), 64'd33);
    expect_eq("res_after_rst", r, {32'd2, 32'd14});

    // Reset while a result is being held.
    op1 = 32'd50; op2 = 32'd6; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = ready;
    end
    expect_eq("hold_before_rst", result, {32'd2, 32'd8});
    #2 rst = 1'b0;
    #1;
    expect_eq("rst_end_ready", 64'(ready), 64'd0);
    expect_eq("rst_end_result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    run_op(32'd12345, 32'd100, 1'b0, 0, lat, r);
    expect_eq("res_12345_100", r, {32'd45, 32'd123});

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
